exu_mdu_ctrl: RTL and testbench
===============================

Name: exu_mdu_ctrl

Overview:
- Requester side of the multi-cycle mul/div start/ready protocol in the EX stage.
- Accepts one M-extension op from EX and routes it to the multiplier (funct3[2]=0) or the divider (funct3[2]=1).
- Holds start for the whole operation, captures the result and presents it to the regfile write arbiter with valid/ready.
- Exports the pending destination register for the hazard unit, plus a pipeline-busy signal.

Parameters:
- DW, 32, operand/result width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  EX issues an M-op.
- req_ready_o  out  1  controller can accept (state IDLE).
- req_op_i  in  3  funct3: MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111.
- req_rs1_i  in  DW  operand 1 (multiplicand/dividend).
- req_rs2_i  in  DW  operand 2 (multiplier/divisor).
- req_rd_i  in  AW  destination register.
- flush_i  in  1  pipeline flush; kill the in-flight op.
- mul_start_o  out  1  start to multiplier; held during the op.
- mul_op_o  out  3  op to multiplier.
- mul_a_o  out  DW  multiplier operand 1.
- mul_b_o  out  DW  multiplier operand 2.
- mul_rd_o  out  AW  rd to multiplier.
- mul_ready_i  in  1  multiplier result valid (1-cycle pulse).
- mul_busy_i  in  1  multiplier busy (status only).
- mul_result_i  in  DW  multiplier result.
- div_start_o  out  1  start to divider.
- div_op_o  out  3  op to divider.
- div_a_o  out  DW  divider operand 1.
- div_b_o  out  DW  divider operand 2.
- div_rd_o  out  AW  rd to divider.
- div_ready_i  in  1  divider result valid (1-cycle pulse).
- div_busy_i  in  1  divider busy (status only).
- div_result_i  in  DW  divider result.
- wb_valid_o  out  1  result available for writeback.
- wb_ready_i  in  1  arbiter accepts the result.
- wb_rd_o  out  AW  writeback address.
- wb_data_o  out  DW  writeback data.
- pend_valid_o  out  1  an op is in flight or awaiting writeback.
- pend_rd_o  out  AW  rd of that op.
- busy_o  out  1  stall request to EX (state != IDLE).

Behaviour:
- State machine: IDLE, MWAIT, DWAIT, WB.
- Reset (rst=0, async): state IDLE. All outputs 0 except req_ready_o=1. Operand/op/rd/result registers cleared.
- IDLE, with req_valid_i=1 and flush_i=0:
  - latch op, rs1, rs2, rd;
  - go to MWAIT if op[2]=0, else DWAIT;
  - req_ready_o=1 only in IDLE.
- IDLE with flush_i=1: request ignored.
- Operand drive: mul_*/div_* data outputs are driven from the latched registers, constant during the op.
- mul_start_o: 1 in MWAIT and 0 in the cycle mul_ready_i=1 (combinational), so the unit sees start low and does not restart. Same rule for div_start_o/DWAIT/div_ready_i.
- MWAIT/DWAIT on ready pulse: capture result_i into the result register, go to WB. Launch-to-WB latency equals unit latency + 1.
- WB: wb_valid_o=1, wb_rd_o and wb_data_o stable.
  - wb_ready_i=1: return to IDLE next cycle.
  - wb_ready_i=0: hold indefinitely (back-pressure).
- Writes to rd=0 still go through writeback; the arbiter drops them.
- pend_valid_o=1 in MWAIT/DWAIT/WB; pend_rd_o is the latched rd.
- busy_o=1 in any state other than IDLE.
- flush_i in MWAIT/DWAIT: start deasserted the same cycle (unit returns to IDLE), result discarded, state IDLE next cycle. A ready pulse coinciding with flush is ignored.
- flush_i in WB: wb_valid_o still shows this cycle; the transfer is not counted and state goes to IDLE. A simultaneous wb_ready_i is treated as a flush win.
- Start is never asserted in IDLE or WB; at most one op is in flight. A new request is accepted no earlier than the cycle after WB completes.
- ready pulse from the non-selected unit: ignored.

Optional Feature:
- Macro MDU_DIVZERO_FAST_EN.
- Defined: in IDLE, a divider op with rs2=0 skips DWAIT and goes directly to WB the next cycle, with div_start_o never asserted.
  - DIV/DIVU result is 0xFFFFFFFF.
  - REM/REMU result is rs1.
- Undefined: divide-by-zero is sent to the divider like any other op.

Test Plan:
- MUL 7*6 → after multiplier ready, wb_valid_o=1, wb_data_o=0x0000002A, wb_rd_o=req_rd; mul_start_o low the cycle ready_i=1; no restart seen (mul_busy_i low after).
- MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE; MULH 0xFFFFFFFF*0xFFFFFFFF → 0x00000000.
- DIV 100/7 → 0x0000000E; REM 100/7 → 0x00000002; mul_start_o stays 0 throughout.
- MUL in flight, flush_i pulsed mid-op → start drops the same cycle, state IDLE next, no wb_valid_o; a following MUL 3*3 returns 9.
- Result ready with wb_ready_i held low 3 cycles → wb_valid_o/wb_data_o stable 4 cycles, busy_o=1 and req_ready_o=0 throughout; rst=0 asserted in WB → all outputs clear immediately.
- DIVU 0x1234/0 → 0xFFFFFFFF and REMU → 0x1234. With MDU_DIVZERO_FAST_EN: wb_valid_o one cycle after accept, div_start_o never high. Without it: the divider is started.

Source files
------------

// File: rtl/exu_mdu_ctrl_if.sv
// Bundle of the EX request, multiplier, divider, writeback and hazard-status
// signals around the mul/div requester.
// modport master : the requester (exu_mdu_ctrl) side
// modport slave  : the environment side (EX stage, mul/div units, WB arbiter)
interface exu_mdu_ctrl_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          req_valid_i;
   logic          req_ready_o;
   logic [2:0]    req_op_i;
   logic [DW-1:0] req_rs1_i;
   logic [DW-1:0] req_rs2_i;
   logic [AW-1:0] req_rd_i;
   logic          flush_i;

   logic          mul_start_o;
   logic [2:0]    mul_op_o;
   logic [DW-1:0] mul_a_o;
   logic [DW-1:0] mul_b_o;
   logic [AW-1:0] mul_rd_o;
   logic          mul_ready_i;
   logic          mul_busy_i;
   logic [DW-1:0] mul_result_i;

   logic          div_start_o;
   logic [2:0]    div_op_o;
   logic [DW-1:0] div_a_o;
   logic [DW-1:0] div_b_o;
   logic [AW-1:0] div_rd_o;
   logic          div_ready_i;
   logic          div_busy_i;
   logic [DW-1:0] div_result_i;

   logic          wb_valid_o;
   logic          wb_ready_i;
   logic [AW-1:0] wb_rd_o;
   logic [DW-1:0] wb_data_o;

   logic          pend_valid_o;
   logic [AW-1:0] pend_rd_o;
   logic          busy_o;

   modport master (
      input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
      input  mul_ready_i, mul_busy_i, mul_result_i,
      input  div_ready_i, div_busy_i, div_result_i,
      input  wb_ready_i,
      output req_ready_o,
      output mul_start_o, mul_op_o, mul_a_o, mul_b_o, mul_rd_o,
      output div_start_o, div_op_o, div_a_o, div_b_o, div_rd_o,
      output wb_valid_o, wb_rd_o, wb_data_o,
      output pend_valid_o, pend_rd_o, busy_o
   );

   modport slave (
      output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
      output mul_ready_i, mul_busy_i, mul_result_i,
      output div_ready_i, div_busy_i, div_result_i,
      output wb_ready_i,
      input  req_ready_o,
      input  mul_start_o, mul_op_o, mul_a_o, mul_b_o, mul_rd_o,
      input  div_start_o, div_op_o, div_a_o, div_b_o, div_rd_o,
      input  wb_valid_o, wb_rd_o, wb_data_o,
      input  pend_valid_o, pend_rd_o, busy_o
   );
endinterface

// File: rtl/exu_mdu_ctrl.sv
// Requester for the multi-cycle mul/div units in EX: accepts one M-op,
// holds start to the selected unit, captures its result and hands it to the
// regfile write arbiter. Exports pending rd and a busy stall to EX.
// Optional: MDU_DIVZERO_FAST_EN resolves divide-by-zero locally (no divider
// launch, straight to WB).
//
// state | meaning
// IDLE  | ready for a new M-op
// MWAIT | multiplier running, start held until its ready pulse
// DWAIT | divider running, start held until its ready pulse
// WB    | result held for the write arbiter
module exu_mdu_ctrl #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   exu_mdu_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, MWAIT, DWAIT, WB} state_e;

   state_e        state_q, state_d;
   logic [2:0]    op_q, op_d;
   logic [DW-1:0] rs1_q, rs1_d;
   logic [DW-1:0] rs2_q, rs2_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [DW-1:0] result_q, result_d;

   // state and operand/result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
         result_q <= result_d;
      end
   end

   // next state, request latch and result capture; flush wins over any
   // coincident ready or writeback acceptance
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rd_d     = rd_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid_i && !bus.flush_i) begin
               op_d  = bus.req_op_i;
               rs1_d = bus.req_rs1_i;
               rs2_d = bus.req_rs2_i;
               rd_d  = bus.req_rd_i;
               if (!bus.req_op_i[2]) begin
                  state_d = MWAIT;
`ifdef MDU_DIVZERO_FAST_EN
               end else if (bus.req_rs2_i == '0) begin
                  // op[1] set selects REM/REMU, which return the dividend
                  state_d  = WB;
                  result_d = bus.req_op_i[1] ? bus.req_rs1_i : '1;
`endif
               end else begin
                  state_d = DWAIT;
               end
            end
         end
         MWAIT: begin
            if (bus.flush_i) begin
               state_d = IDLE;
            end else if (bus.mul_ready_i) begin
               result_d = bus.mul_result_i;
               state_d  = WB;
            end
         end
         DWAIT: begin
            if (bus.flush_i) begin
               state_d = IDLE;
            end else if (bus.div_ready_i) begin
               result_d = bus.div_result_i;
               state_d  = WB;
            end
         end
         WB: begin
            if (bus.flush_i || bus.wb_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // outputs; start drops combinationally on ready or flush so the unit
   // never sees a second launch
   always_comb begin
      bus.req_ready_o  = (state_q == IDLE);
      bus.mul_start_o  = (state_q == MWAIT) && !bus.mul_ready_i && !bus.flush_i;
      bus.mul_op_o     = op_q;
      bus.mul_a_o      = rs1_q;
      bus.mul_b_o      = rs2_q;
      bus.mul_rd_o     = rd_q;
      bus.div_start_o  = (state_q == DWAIT) && !bus.div_ready_i && !bus.flush_i;
      bus.div_op_o     = op_q;
      bus.div_a_o      = rs1_q;
      bus.div_b_o      = rs2_q;
      bus.div_rd_o     = rd_q;
      bus.wb_valid_o   = (state_q == WB);
      bus.wb_rd_o      = rd_q;
      bus.wb_data_o    = result_q;
      bus.pend_valid_o = (state_q != IDLE);
      bus.pend_rd_o    = rd_q;
      bus.busy_o       = (state_q != IDLE);
   end
endmodule

// File: tb/tb_exu_mdu_ctrl.sv
// Bench for exu_mdu_ctrl: behavioural mul/div units with adjustable latency,
// results predicted from RISC-V M-extension arithmetic.
`timescale 1ns/1ps
module tb_exu_mdu_ctrl;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   exu_mdu_ctrl_if #(.DW(DW), .AW(AW)) bus ();
   exu_mdu_ctrl #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // RISC-V M-extension semantics
   function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (op)
         3'b000: begin t = ua * ub; return t[31:0]; end
         3'b001: begin t = sa * sb; return t[63:32]; end
         3'b010: begin t = sa * ub; return t[63:32]; end
         3'b011: begin t = ua * ub; return t[63:32]; end
         3'b100: begin if (b == 0) return 32'hFFFF_FFFF; t = sa / sb; return t[31:0]; end
         3'b101: begin if (b == 0) return 32'hFFFF_FFFF; t = ua / ub; return t[31:0]; end
         3'b110: begin if (b == 0) return a; t = sa % sb; return t[31:0]; end
         default: begin if (b == 0) return a; t = ua % ub; return t[31:0]; end
      endcase
   endfunction

   // behavioural units: launch when start seen, abort if start drops, pulse ready after lat
   int          m_lat = 3, d_lat = 4;
   int          m_starts = 0, d_starts = 0;
   int          m_cnt = 0, d_cnt = 0;
   logic        m_act = 0, m_busy = 0, m_rdy = 0, d_act = 0, d_busy = 0, d_rdy = 0;
   logic [2:0]  m_op = 0, d_op = 0;
   logic [31:0] m_a = 0, m_b = 0, m_res = 0, d_a = 0, d_b = 0, d_res = 0;
   logic        inj_mul_rdy = 0, inj_div_rdy = 0;

   assign bus.mul_ready_i  = m_rdy | inj_mul_rdy;
   assign bus.mul_busy_i   = m_busy;
   assign bus.mul_result_i = m_res;
   assign bus.div_ready_i  = d_rdy | inj_div_rdy;
   assign bus.div_busy_i   = d_busy;
   assign bus.div_result_i = d_res;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_act <= 0; m_busy <= 0; m_rdy <= 0; m_cnt <= 0;
      end else begin
         m_rdy <= 0;
         if (m_act) begin
            if (!bus.mul_start_o) begin
               m_act <= 0; m_busy <= 0;
            end else if (m_cnt == 0) begin
               m_rdy <= 1; m_res <= ref_op(m_op, m_a, m_b); m_act <= 0; m_busy <= 0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end else if (bus.mul_start_o) begin
            m_act <= 1; m_busy <= 1; m_cnt <= m_lat; m_starts <= m_starts + 1;
            m_op <= bus.mul_op_o; m_a <= bus.mul_a_o; m_b <= bus.mul_b_o;
         end
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_act <= 0; d_busy <= 0; d_rdy <= 0; d_cnt <= 0;
      end else begin
         d_rdy <= 0;
         if (d_act) begin
            if (!bus.div_start_o) begin
               d_act <= 0; d_busy <= 0;
            end else if (d_cnt == 0) begin
               d_rdy <= 1; d_res <= ref_op(d_op, d_a, d_b); d_act <= 0; d_busy <= 0;
            end else begin
               d_cnt <= d_cnt - 1;
            end
         end else if (bus.div_start_o) begin
            d_act <= 1; d_busy <= 1; d_cnt <= d_lat; d_starts <= d_starts + 1;
            d_op <= bus.div_op_o; d_a <= bus.div_a_o; d_b <= bus.div_b_o;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      bus.req_valid_i = 1; bus.req_op_i = op; bus.req_rs1_i = a; bus.req_rs2_i = b;
      bus.req_rd_i = rd;
      @(negedge clk);
      bus.req_valid_i = 0; bus.req_op_i = 3'($urandom); bus.req_rs1_i = $urandom;
      bus.req_rs2_i = $urandom; bus.req_rd_i = 5'($urandom);
   endtask

   // returns in the first WB cycle (negedge + 1) or after limit cycles
   task automatic wait_wb(input int limit, output bit timeout, output int cycles,
                          output bit overlap);
      timeout = 1; cycles = 0; overlap = 0;
      for (int i = 0; i < limit; i++) begin
         #1;
         if ((bus.mul_ready_i && bus.mul_start_o) || (bus.div_ready_i && bus.div_start_o))
            overlap = 1;
         if (bus.wb_valid_o) begin
            timeout = 0;
            break;
         end
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic retire();
      bus.wb_ready_i = 1;
      @(negedge clk);
      bus.wb_ready_i = 0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int bp, output logic [31:0] data,
                         output logic [4:0] wrd, output bit timeout, output int cycles,
                         output bit overlap);
      issue(op, a, b, rd);
      wait_wb(100, timeout, cycles, overlap);
      data = bus.wb_data_o;
      wrd  = bus.wb_rd_o;
      repeat (bp) @(negedge clk);
      #1;
      retire();
   endtask

   task automatic test_reset();
      rst = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b exp 1", bus.req_ready_o); end
      checks++; if ({bus.mul_start_o, bus.div_start_o, bus.wb_valid_o, bus.pend_valid_o, bus.busy_o} !== 5'b0) begin
         errors++; $display("FAIL reset_ctl: got %b exp 00000", {bus.mul_start_o, bus.div_start_o, bus.wb_valid_o, bus.pend_valid_o, bus.busy_o}); end
      checks++; if ({bus.mul_a_o, bus.mul_b_o, bus.wb_data_o, bus.wb_rd_o, bus.mul_op_o} !== '0) begin
         errors++; $display("FAIL reset_data: got %h exp 0", {bus.mul_a_o, bus.mul_b_o, bus.wb_data_o, bus.wb_rd_o, bus.mul_op_o}); end
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_mul_basic();
      int ms0, ds0, cyc; bit to, ov;
      ms0 = m_starts; ds0 = d_starts;
      m_lat = 3;
      issue(3'b000, 32'd7, 32'd6, 5'd9);
      #1;
      checks++; if ({bus.pend_valid_o, bus.busy_o, bus.req_ready_o, bus.mul_start_o, bus.div_start_o} !== 5'b11010) begin
         errors++; $display("FAIL mul_inflight_flags: got %b exp 11010", {bus.pend_valid_o, bus.busy_o, bus.req_ready_o, bus.mul_start_o, bus.div_start_o}); end
      checks++; if (bus.pend_rd_o !== 5'd9) begin errors++; $display("FAIL mul_pend_rd: got %0d exp 9", bus.pend_rd_o); end
      checks++; if ({bus.mul_a_o, bus.mul_b_o, bus.mul_op_o} !== {32'd7, 32'd6, 3'b000}) begin
         errors++; $display("FAIL mul_operands: got %h exp %h", {bus.mul_a_o, bus.mul_b_o, bus.mul_op_o}, {32'd7, 32'd6, 3'b000}); end
      wait_wb(100, to, cyc, ov);
      checks++; if (to) begin errors++; $display("FAIL mul_timeout: got no wb_valid exp wb_valid"); end
      checks++; if (ov) begin errors++; $display("FAIL mul_start_overlap: got start high with ready exp start low"); end
      // start seen at the edge after accept, ready m_lat+1 edges later, WB one edge after that
      checks++; if (cyc !== m_lat + 3) begin errors++; $display("FAIL mul_latency: got %0d exp %0d", cyc, m_lat + 3); end
      checks++; if (bus.wb_data_o !== 32'h2A) begin errors++; $display("FAIL mul_data: got %h exp 0000002a", bus.wb_data_o); end
      checks++; if (bus.wb_rd_o !== 5'd9) begin errors++; $display("FAIL mul_wb_rd: got %0d exp 9", bus.wb_rd_o); end
      retire();
      repeat (4) @(negedge clk);
      #1;
      checks++; if (m_starts - ms0 !== 1 || d_starts - ds0 !== 0) begin
         errors++; $display("FAIL mul_start_count: got mul %0d div %0d exp mul 1 div 0", m_starts - ms0, d_starts - ds0); end
      checks++; if (bus.mul_busy_i !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++; $display("FAIL mul_no_restart: got unit busy %b ctrl busy %b exp 0 0", bus.mul_busy_i, bus.busy_o); end
   endtask

   task automatic test_mulh();
      logic [31:0] d; logic [4:0] r; bit to, ov; int cyc;
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, d, r, to, cyc, ov);
      checks++; if (to || d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu: got %h (timeout %b) exp fffffffe", d, to); end
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, d, r, to, cyc, ov);
      checks++; if (to || d !== 32'h0) begin errors++; $display("FAIL mulh: got %h (timeout %b) exp 00000000", d, to); end
   endtask

   task automatic test_div();
      logic [31:0] d; logic [4:0] r; bit to, ov; int cyc, ms0, ds0;
      ms0 = m_starts; ds0 = d_starts;
      run_op(3'b100, 32'd100, 32'd7, 5'd3, 0, d, r, to, cyc, ov);
      checks++; if (to || d !== 32'hE || r !== 5'd3) begin errors++; $display("FAIL div: got %h rd %0d exp 0000000e rd 3", d, r); end
      checks++; if (ov) begin errors++; $display("FAIL div_start_overlap: got start high with ready exp start low"); end
      run_op(3'b110, 32'd100, 32'd7, 5'd4, 0, d, r, to, cyc, ov);
      checks++; if (to || d !== 32'h2) begin errors++; $display("FAIL rem: got %h exp 00000002", d); end
      checks++; if (m_starts - ms0 !== 0 || d_starts - ds0 !== 2) begin
         errors++; $display("FAIL div_start_count: got mul %0d div %0d exp mul 0 div 2", m_starts - ms0, d_starts - ds0); end
   endtask

   task automatic test_flush();
      logic [31:0] d; logic [4:0] r; bit to, ov; int cyc, seen;
      m_lat = 8;
      issue(3'b000, 32'd5, 32'd5, 5'd3);
      repeat (2) @(negedge clk);
      bus.flush_i = 1;
      #1;
      checks++; if (bus.mul_start_o !== 1'b0) begin errors++; $display("FAIL flush_start_drop: got %b exp 0", bus.mul_start_o); end
      @(negedge clk);
      bus.flush_i = 0;
      #1;
      checks++; if ({bus.req_ready_o, bus.busy_o, bus.pend_valid_o} !== 3'b100) begin
         errors++; $display("FAIL flush_idle: got %b exp 100", {bus.req_ready_o, bus.busy_o, bus.pend_valid_o}); end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         if (bus.wb_valid_o) seen++;
      end
      checks++; if (seen !== 0 || bus.mul_busy_i !== 1'b0) begin
         errors++; $display("FAIL flush_no_wb: got wb cycles %0d unit busy %b exp 0 0", seen, bus.mul_busy_i); end
      m_lat = 3;
      run_op(3'b000, 32'd3, 32'd3, 5'd7, 0, d, r, to, cyc, ov);
      checks++; if (to || d !== 32'd9) begin errors++; $display("FAIL flush_next_mul: got %h exp 00000009", d); end
      // ready pulse coincident with flush in DWAIT
      d_lat = 8;
      issue(3'b101, 32'd50, 32'd5, 5'd8);
      repeat (2) @(negedge clk);
      bus.flush_i = 1; inj_div_rdy = 1;
      @(negedge clk);
      bus.flush_i = 0; inj_div_rdy = 0;
      #1;
      checks++; if ({bus.busy_o, bus.wb_valid_o} !== 2'b00) begin
         errors++; $display("FAIL flush_with_ready: got busy,wb_valid %b exp 00", {bus.busy_o, bus.wb_valid_o}); end
      d_lat = 4;
      // flush in WB beats a simultaneous wb_ready
      issue(3'b000, 32'd2, 32'd2, 5'd6);
      wait_wb(100, to, cyc, ov);
      bus.flush_i = 1; bus.wb_ready_i = 1;
      #1;
      checks++; if (to || bus.wb_valid_o !== 1'b1) begin errors++; $display("FAIL flush_wb_visible: got %b exp 1", bus.wb_valid_o); end
      @(negedge clk);
      bus.flush_i = 0; bus.wb_ready_i = 0;
      #1;
      checks++; if ({bus.busy_o, bus.wb_valid_o, bus.req_ready_o} !== 3'b001) begin
         errors++; $display("FAIL flush_wb_idle: got %b exp 001", {bus.busy_o, bus.wb_valid_o, bus.req_ready_o}); end
   endtask

   task automatic test_backpressure();
      bit to, ov; int cyc; logic [31:0] exp;
      exp = ref_op(3'b000, 32'h11, 32'h22);
      issue(3'b000, 32'h11, 32'h22, 5'd12);
      wait_wb(100, to, cyc, ov);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (to || {bus.wb_valid_o, bus.busy_o, bus.req_ready_o} !== 3'b110 || bus.wb_data_o !== exp || bus.wb_rd_o !== 5'd12) begin
            errors++; $display("FAIL backpressure_hold[%0d]: got flags %b data %h rd %0d exp 110 %h 12", i,
                               {bus.wb_valid_o, bus.busy_o, bus.req_ready_o}, bus.wb_data_o, bus.wb_rd_o, exp); end
         @(negedge clk); #1;
      end
      rst = 0;
      #1;
      checks++; if ({bus.wb_valid_o, bus.busy_o, bus.pend_valid_o, bus.req_ready_o} !== 4'b0001) begin
         errors++; $display("FAIL reset_in_wb_flags: got %b exp 0001", {bus.wb_valid_o, bus.busy_o, bus.pend_valid_o, bus.req_ready_o}); end
      checks++; if ({bus.wb_data_o, bus.wb_rd_o, bus.mul_a_o, bus.pend_rd_o} !== '0) begin
         errors++; $display("FAIL reset_in_wb_data: got %h exp 0", {bus.wb_data_o, bus.wb_rd_o, bus.mul_a_o, bus.pend_rd_o}); end
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_divzero();
      logic [31:0] d; logic [4:0] r; bit to, ov; int cyc, ds0;
      ds0 = d_starts;
      run_op(3'b101, 32'h1234, 32'h0, 5'd10, 0, d, r, to, cyc, ov);
      checks++; if (to || d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero: got %h exp ffffffff", d); end
`ifdef MDU_DIVZERO_FAST_EN
      checks++; if (cyc !== 0) begin errors++; $display("FAIL divzero_fast_latency: got %0d exp 0", cyc); end
`endif
      run_op(3'b111, 32'h1234, 32'h0, 5'd11, 0, d, r, to, cyc, ov);
      checks++; if (to || d !== 32'h1234) begin errors++; $display("FAIL remu_zero: got %h exp 00001234", d); end
`ifdef MDU_DIVZERO_FAST_EN
      checks++; if (d_starts - ds0 !== 0) begin errors++; $display("FAIL divzero_starts: got %0d exp 0", d_starts - ds0); end
`else
      checks++; if (d_starts - ds0 !== 2) begin errors++; $display("FAIL divzero_starts: got %0d exp 2", d_starts - ds0); end
`endif
   endtask

   task automatic test_stray_ready();
      bit to, ov; int cyc;
      m_lat = 6;
      issue(3'b000, 32'd2, 32'd3, 5'd5);
      inj_div_rdy = 1;
      @(negedge clk);
      inj_div_rdy = 0;
      #1;
      checks++; if ({bus.wb_valid_o, bus.busy_o, bus.mul_start_o} !== 3'b011) begin
         errors++; $display("FAIL stray_ready: got wb,busy,start %b exp 011", {bus.wb_valid_o, bus.busy_o, bus.mul_start_o}); end
      wait_wb(100, to, cyc, ov);
      checks++; if (to || bus.wb_data_o !== 32'd6) begin errors++; $display("FAIL stray_ready_result: got %h exp 00000006", bus.wb_data_o); end
      retire();
      m_lat = 3;
   endtask

   task automatic test_random();
      logic [2:0] op; logic [31:0] a, b, d, exp; logic [4:0] rd, r;
      bit to, ov; int cyc, ms0, ds0, em, ed;
      for (int n = 0; n < 30; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         b  = ($urandom_range(0, 4) == 0) ? 32'h0 : (($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom);
         rd = 5'($urandom);
         m_lat = $urandom_range(0, 5); d_lat = $urandom_range(0, 5);
         exp = ref_op(op, a, b);
         ms0 = m_starts; ds0 = d_starts;
         em = op[2] ? 0 : 1;
         ed = op[2] ? 1 : 0;
`ifdef MDU_DIVZERO_FAST_EN
         if (op[2] && b == 0) ed = 0;
`endif
         run_op(op, a, b, rd, $urandom_range(0, 3), d, r, to, cyc, ov);
         checks++;
         if (to || ov || d !== exp || r !== rd) begin
            errors++; $display("FAIL random[%0d] op %0d a %h b %h: got %h rd %0d to %b ov %b exp %h rd %0d", n, op, a, b, d, r, to, ov, exp, rd); end
         checks++;
         if (m_starts - ms0 !== em || d_starts - ds0 !== ed) begin
            errors++; $display("FAIL random_starts[%0d]: got mul %0d div %0d exp mul %0d div %0d", n, m_starts - ms0, d_starts - ds0, em, ed); end
      end
   endtask

   initial begin
      bus.req_valid_i = 0; bus.req_op_i = 0; bus.req_rs1_i = 0; bus.req_rs2_i = 0;
      bus.req_rd_i = 0; bus.flush_i = 0; bus.wb_ready_i = 0;
      test_reset();
      test_mul_basic();
      test_mulh();
      test_div();
      test_flush();
      test_backpressure();
      test_divzero();
      test_stray_ready();
      test_random();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
